cordic_sched: RTL and testbench

- Shares one pipelined Cordic rotator core among NREQ independent requesters.
- Each requester has a valid/ready request port and a valid/ready response port.
- Arbitration is round-robin; one issue per cycle at most.
- A tag pipeline runs alongside the core and routes each result back to its requester. A blocked response stalls the whole core through its en input.
- The scheduler instantiates the Cordic core internally. It sits between the DSP front-ends (NCO, mixers) and the shared rotator.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic.sv | 74 +++++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cordic_sched.sv | 99 +++++++++
 tb/tb_cordic_sched.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the Cordic rotator and its request scheduler.
// The arctangent table is kept at 32-bit binary-angle precision and rounded to the data width.
package cordic_pkg;

    localparam int CORDIC_DW   = 10;
    localparam int CORDIC_LAT  = 10;
    localparam int CORDIC_NREQ = 4;
    localparam int TAG_W       = $clog2(CORDIC_NREQ);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic signed [CORDIC_DW-1:0] x;
        logic signed [CORDIC_DW-1:0] y;
        logic signed [CORDIC_DW-1:0] a;
    } cordic_req_t;

    // atan(2^-stage) where 2^(dw-1) represents pi, rounded to nearest
    function automatic int cordic_atan(input int stage, input int dw);
        logic [31:0] c;
        case (stage)
            0:       c = 32'h2000_0000;
            1:       c = 32'h12E4_051E;
            2:       c = 32'h09FB_385B;
            3:       c = 32'h0511_11D4;
            4:       c = 32'h028B_0D43;
            5:       c = 32'h0145_D7E1;
            6:       c = 32'h00A2_F61E;
            7:       c = 32'h0051_7C55;
            8:       c = 32'h0028_BE53;
            9:       c = 32'h0014_5F2F;
            10:      c = 32'h000A_2F98;
            11:      c = 32'h0005_17CC;
            12:      c = 32'h0002_8BE6;
            13:      c = 32'h0001_45F3;
            default: c = 32'h0;
        endcase
        return int'((c + (32'd1 << (31 - dw))) >> (32 - dw));
    endfunction

endpackage

// File: rtl/cordic.sv
// Pipelined Cordic rotator, one micro-rotation per stage, output gain-compensated.
// Two guard bits absorb the ~1.647 Cordic gain before compensation.
module cordic import cordic_pkg::*; #(
    parameter int DW  = CORDIC_DW,
    parameter int NST = CORDIC_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] xin,
    input  logic signed [DW-1:0] yin,
    input  logic signed [DW-1:0] ain,
    output logic signed [DW-1:0] xout,
    output logic signed [DW-1:0] yout,
    output logic signed [DW-1:0] arem
);

    localparam int IW = DW + 2;

    logic signed [IW-1:0] x_q [NST];
    logic signed [IW-1:0] y_q [NST];
    logic signed [DW-1:0] z_q [NST];
    logic signed [IW-1:0] x_in [NST];
    logic signed [IW-1:0] y_in [NST];
    logic signed [DW-1:0] z_in [NST];
    logic signed [IW-1:0] x_d [NST];
    logic signed [IW-1:0] y_d [NST];
    logic signed [DW-1:0] z_d [NST];

    for (genvar gi = 0; gi < NST; gi++) begin : g_stage
        localparam logic signed [DW-1:0] ATAN = DW'(cordic_atan(gi, DW));
        logic neg;
        if (gi == 0) begin : g_first
            assign x_in[gi] = IW'(xin);
            assign y_in[gi] = IW'(yin);
            assign z_in[gi] = ain;
        end else begin : g_chain
            assign x_in[gi] = x_q[gi-1];
            assign y_in[gi] = y_q[gi-1];
            assign z_in[gi] = z_q[gi-1];
        end
        // rotate towards zero residual angle
        assign neg      = z_in[gi][DW-1];
        assign x_d[gi]  = neg ? x_in[gi] + (y_in[gi] >>> gi) : x_in[gi] - (y_in[gi] >>> gi);
        assign y_d[gi]  = neg ? y_in[gi] - (x_in[gi] >>> gi) : y_in[gi] + (x_in[gi] >>> gi);
        assign z_d[gi]  = neg ? z_in[gi] + ATAN : z_in[gi] - ATAN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NST; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NST; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                z_q[i] <= z_d[i];
            end
        end
    end

    // 1/K ~= 2^-1 + 2^-4 + 2^-5 + 2^-7 + 2^-9
    function automatic logic signed [IW-1:0] gain_comp(input logic signed [IW-1:0] v);
        return (v >>> 1) + (v >>> 4) + (v >>> 5) + (v >>> 7) + (v >>> 9);
    endfunction

    assign xout = DW'(gain_comp(x_q[NST-1]));
    assign yout = DW'(gain_comp(y_q[NST-1]));
    assign arem = z_q[NST-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined Cordic among NREQ requesters.
// A tag pipe tracks the owner of each in-flight op; a blocked head response freezes everything.
module cordic_sched import cordic_pkg::*; #(
    parameter int NREQ = 4,
    parameter int DW   = 10,
    parameter int LAT  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_y,
    input  logic [NREQ*DW-1:0] req_a,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_x,
    output logic [DW-1:0]      rsp_y,
    output logic [DW-1:0]      rsp_arem,
    output logic               busy
);

    localparam int TW = $clog2(NREQ);

    logic [LAT-1:0]       vld_q;
    logic [TW-1:0]        tag_q [LAT];
    logic [TW-1:0]        ptr_q;
    logic [TW-1:0]        ptr_d;
    logic [TW-1:0]        gnt_idx;
    logic [TW-1:0]        head_tag;
    logic [NREQ-1:0]      gnt;
    logic                 head_v;
    logic                 stall;
    logic                 grant_any;
    logic signed [DW-1:0] core_x;
    logic signed [DW-1:0] core_y;
    logic signed [DW-1:0] core_a;

    assign head_v   = vld_q[LAT-1];
    assign head_tag = tag_q[LAT-1];
    assign stall    = head_v && !rsp_ready[head_tag];

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (rst_n && !stall),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign grant_any = |gnt;
    assign req_ready = gnt;

    always_comb begin
        core_x = '0;
        core_y = '0;
        core_a = '0;
        ptr_d  = ptr_q;
        if (grant_any) begin
            core_x = req_x[gnt_idx*DW +: DW];
            core_y = req_y[gnt_idx*DW +: DW];
            core_a = req_a[gnt_idx*DW +: DW];
            ptr_d  = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (!stall) begin
            vld_q    <= {vld_q[LAT-2:0], grant_any};
            tag_q[0] <= gnt_idx;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (head_v) rsp_valid[head_tag] = 1'b1;
    end

    assign busy = |vld_q;

    cordic #(.DW(DW), .NST(LAT)) u_cordic (
        .clk  (clk),
        .rst  (~rst_n),
        .en   (!stall),
        .xin  (core_x),
        .yin  (core_y),
        .ain  (core_a),
        .xout (rsp_x),
        .yout (rsp_y),
        .arem (rsp_arem)
    );

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized bench for cordic_sched against a transaction-level scoreboard and numeric Cordic model.
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 10;
    localparam int LAT  = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_x = '0;
    logic [NREQ*DW-1:0] req_y = '0;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready = '1;
    logic [DW-1:0]      rsp_x;
    logic [DW-1:0]      rsp_y;
    logic [DW-1:0]      rsp_arem;
    logic               busy;

    always #5 clk = ~clk;

    cordic_sched #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_a     (req_a),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_arem  (rsp_arem),
        .busy      (busy)
    );

    typedef struct {
        tag_t tag;
        int   age;
        int   ex;
        int   ey;
        int   ez;
    } op_t;

    op_t             q[$];
    int              ptr_m = 0;
    int              cyc = 0;
    int              atan_tab[LAT];
    int              gnt_log[$];
    int              rsp_run = 0;
    int              rsp_run_max = 0;
    logic [NREQ-1:0] obs_gnt;
    logic [NREQ-1:0] obs_rsp;
    int              obs_y;
    int              obs_cyc;
    int              checks = 0;
    int              errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wrap(input int v);
        int w;
        w = v & ((1 << DW) - 1);
        if (w >= (1 << (DW - 1))) w = w - (1 << DW);
        return w;
    endfunction

    function automatic int comp(input int v);
        return (v >>> 1) + (v >>> 4) + (v >>> 5) + (v >>> 7) + (v >>> 9);
    endfunction

    // Cordic rotation mode: drive the angle to zero, then scale by ~1/K
    task automatic golden(input int x, input int y, input int a, output int xo, output int yo, output int zo);
        int xc, yc, zc, xn;
        xc = x; yc = y; zc = a;
        for (int i = 0; i < LAT; i++) begin
            if (zc < 0) begin
                xn = xc + (yc >>> i); yc = yc - (xc >>> i); zc = zc + atan_tab[i];
            end else begin
                xn = xc - (yc >>> i); yc = yc + (xc >>> i); zc = zc - atan_tab[i];
            end
            xc = xn;
        end
        xo = wrap(comp(xc));
        yo = wrap(comp(yc));
        zo = wrap(zc);
    endtask

    task automatic set_req(input int i, input cordic_req_t r);
        req_x[i*DW +: DW] = r.x;
        req_y[i*DW +: DW] = r.y;
        req_a[i*DW +: DW] = r.a;
    endtask

    task automatic rand_payloads();
        cordic_req_t r;
        for (int i = 0; i < NREQ; i++) begin
            r.x = DW'(int'($urandom_range(300)) - 150);
            r.y = DW'(int'($urandom_range(300)) - 150);
            r.a = DW'(int'($urandom_range(400)) - 200);
            set_req(i, r);
        end
    endtask

    // Called just after a rising edge with this cycle's inputs applied; leaves just after the next one.
    task automatic run_cycle();
        logic [NREQ-1:0] exp_gnt, exp_rsp;
        bit   head, stl;
        int   g, k;
        op_t  o;
        @(negedge clk);
        exp_gnt = '0; exp_rsp = '0; head = 0; stl = 0; g = -1;
        if (!rst_n) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (q.size() > 0 && q[0].age == LAT) begin
                head = 1;
                exp_rsp[q[0].tag] = 1'b1;
                stl = !rsp_ready[q[0].tag];
            end
            if (!stl) begin
                for (int n = 0; n < NREQ; n++) begin
                    k = (ptr_m + n) % NREQ;
                    if (g < 0 && req_valid[k]) g = k;
                end
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
        end
        check("req_ready", req_ready, exp_gnt);
        check("rsp_valid", rsp_valid, exp_rsp);
        check("busy", busy, q.size() > 0);
        if (head) begin
            check("rsp_x", $signed(rsp_x), q[0].ex);
            check("rsp_y", $signed(rsp_y), q[0].ey);
            check("rsp_arem", $signed(rsp_arem), q[0].ez);
        end
        obs_gnt = req_ready;
        obs_rsp = rsp_valid;
        obs_y   = $signed(rsp_y);
        obs_cyc = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
        rsp_run = (rsp_valid != '0) ? rsp_run + 1 : 0;
        if (rsp_run > rsp_run_max) rsp_run_max = rsp_run;
        if (rst_n && !stl) begin
            if (head) begin
                $display("rsp req=%0d x=%0d y=%0d arem=%0d cyc=%0d",
                         q[0].tag, $signed(rsp_x), $signed(rsp_y), $signed(rsp_arem), cyc);
                void'(q.pop_front());
            end
            foreach (q[j]) q[j].age++;
            if (g >= 0) begin
                o.tag = tag_t'(g);
                o.age = 1;
                golden($signed(req_x[g*DW +: DW]), $signed(req_y[g*DW +: DW]),
                       $signed(req_a[g*DW +: DW]), o.ex, o.ey, o.ez);
                q.push_back(o);
                ptr_m = (g + 1) % NREQ;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '1;
        rst_n = 1'b0;
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        cordic_req_t r;
        int acc, stalls, grants;
        bit found;

        for (int i = 0; i < LAT; i++)
            atan_tab[i] = $rtoi($floor($atan(2.0 ** (-i)) / 3.141592653589793 * real'(1 << (DW - 1)) + 0.5));

        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        run_cycle();
        run_cycle();
        req_valid = '0;
        rst_n = 1'b1;

        // single operation, latency and near-zero y
        r.x = 10'sd500; r.y = '0; r.a = '0;
        set_req(1, r);
        req_valid = 4'b0010;
        run_cycle();
        check("single_gnt", obs_gnt, 4'b0010);
        acc = obs_cyc;
        req_valid = '0;
        found = 0;
        for (int n = 0; n < 3 * LAT; n++) begin
            run_cycle();
            if (obs_rsp != '0 && !found) begin
                found = 1;
                check("single_lat", obs_cyc - acc, LAT);
                check("single_y_small", (obs_y <= 2 && obs_y >= -2), 1);
            end
        end
        if (!found) check("single_timeout", 0, 1);

        // round-robin with all requesters active
        do_reset();
        gnt_log.delete();
        rsp_run_max = 0;
        req_valid = '1;
        for (int n = 0; n < 12; n++) begin
            rand_payloads();
            run_cycle();
        end
        drain(2 * LAT);
        check("rr_count", gnt_log.size(), 12);
        for (int n = 0; n < 12 && n < gnt_log.size(); n++) check("rr_order", gnt_log[n], n % 4);
        check("rr_rsp_run", rsp_run_max, 12);

        // fairness between requesters 2 and 3
        do_reset();
        gnt_log.delete();
        req_valid = 4'b1100;
        for (int n = 0; n < 8; n++) begin
            rand_payloads();
            run_cycle();
        end
        drain(2 * LAT);
        check("fair_count", gnt_log.size(), 8);
        for (int n = 0; n < 8 && n < gnt_log.size(); n++) check("fair_order", gnt_log[n], 2 + (n % 2));

        // backpressure on requester 2 for five cycles
        do_reset();
        gnt_log.delete();
        stalls = 0;
        req_valid = '1;
        for (int n = 0; n < LAT + 8; n++) begin
            rand_payloads();
            if (q.size() > 0 && q[0].age == LAT && q[0].tag == 2 && stalls < 5) begin
                rsp_ready = 4'b1011;
                stalls++;
            end else begin
                rsp_ready = '1;
            end
            run_cycle();
        end
        grants = gnt_log.size();
        drain(3 * LAT);
        check("bp_stalls", stalls, 5);
        check("bp_grants", grants, LAT + 8 - 5);

        // streaming throughput from requester 0
        do_reset();
        gnt_log.delete();
        rsp_run_max = 0;
        req_valid = 4'b0001;
        for (int n = 0; n < 64; n++) begin
            r.x = 10'sd300; r.y = '0; r.a = DW'(n);
            set_req(0, r);
            run_cycle();
        end
        drain(2 * LAT);
        check("stream_gnts", gnt_log.size(), 64);
        check("stream_run", rsp_run_max, 64);

        // random traffic with random backpressure
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_payloads();
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom | $urandom);
            run_cycle();
        end
        req_valid = '0;
        rsp_ready = '1;
        for (int n = 0; n < 400 && q.size() > 0; n++) run_cycle();
        check("rand_drained", busy, 0);

        // asynchronous reset with six ops in flight
        req_valid = 4'b0010;
        for (int n = 0; n < 6; n++) begin
            rand_payloads();
            run_cycle();
        end
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rsp", rsp_valid, 0);
        check("arst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        req_valid = '0;
        rst_n = 1'b1;
        for (int n = 0; n < LAT + 3; n++) run_cycle();
        req_valid = '1;
        rand_payloads();
        run_cycle();
        check("arst_next_gnt", obs_gnt, 4'b0001);
        drain(2 * LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
